// File: rtl/phase_reconstructor_ng.sv
// N-phase stream reconstructor: measured samples pass through a one-deep output register and
// the unmeasured phase is injected once per frame as SUM_TARGET minus the frame sum.
module phase_reconstructor_ng #(
  parameter int unsigned N_PHASES        = 6,
  parameter int unsigned MISSING_PHASE   = 5,
  parameter int unsigned DATA_PATH_WIDTH = 16,
  parameter int unsigned DEST_WIDTH      = 8,
  parameter bit          SIGNED_MODE     = 1'b0,
  parameter int          SUM_TARGET      = 196605
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [DATA_PATH_WIDTH-1:0] phases_in_data,
  input  logic [DEST_WIDTH-1:0]      phases_in_dest,
  input  logic                       phases_in_valid,
  output logic                       phases_in_ready,
  output logic [DATA_PATH_WIDTH-1:0] phases_out_data,
  output logic [DEST_WIDTH-1:0]      phases_out_dest,
  output logic                       phases_out_valid,
  input  logic                       phases_out_ready,
  output logic                       frame_error,
  output logic                       saturated
);

  localparam int unsigned W  = DATA_PATH_WIDTH;
  localparam int unsigned AW = W + $clog2(N_PHASES) + 2;
  localparam int unsigned RW = AW + 1;

  localparam logic [N_PHASES-1:0]   FullMask    = ~(N_PHASES'(1) << MISSING_PHASE);
  localparam logic [DEST_WIDTH-1:0] DestLimit   = DEST_WIDTH'(N_PHASES);
  localparam logic [DEST_WIDTH-1:0] DestMissing = DEST_WIDTH'(MISSING_PHASE);

  localparam logic signed [RW-1:0] Target  = RW'(SUM_TARGET);
  localparam logic signed [RW-1:0] LoBound = SIGNED_MODE ?
      {{(RW-W+1){1'b1}}, {(W-1){1'b0}}} : '0;
  localparam logic signed [RW-1:0] HiBound = SIGNED_MODE ?
      {{(RW-W+1){1'b0}}, {(W-1){1'b1}}} : {{(RW-W){1'b0}}, {W{1'b1}}};
  localparam logic [W-1:0] LoData = SIGNED_MODE ? {1'b1, {(W-1){1'b0}}} : '0;
  localparam logic [W-1:0] HiData = SIGNED_MODE ? {1'b0, {(W-1){1'b1}}} : '1;

  typedef enum logic [0:0] {StCollect, StEmit} state_e;

  state_e                 state_q, state_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [N_PHASES-1:0]    bitmap_q, bitmap_d;
  logic                   out_valid_q, out_valid_d;
  logic [W-1:0]           out_data_q, out_data_d;
  logic [DEST_WIDTH-1:0]  out_dest_q, out_dest_d;
  logic                   frame_error_q, frame_error_d;
  logic                   saturated_q, saturated_d;

  logic                   out_free;
  logic                   in_fire;
  logic signed [AW-1:0]   sample_ext;
  logic [N_PHASES-1:0]    dest_bit;
  logic                   dest_illegal;
  logic                   dest_dup;
  logic signed [RW-1:0]   recon_raw;
  logic [W-1:0]           recon_data;
  logic                   recon_sat;

  assign out_free        = ~out_valid_q | phases_out_ready;
  assign phases_in_ready = ~reset & out_free & (state_q == StCollect);
  assign in_fire         = phases_in_valid & phases_in_ready;

  assign sample_ext = SIGNED_MODE ? {{(AW-W){phases_in_data[W-1]}}, phases_in_data}
                                  : {{(AW-W){1'b0}}, phases_in_data};

  // Out-of-range dests shift the single bit off the end, so they never touch the bitmap.
  assign dest_bit     = N_PHASES'(1) << phases_in_dest;
  assign dest_illegal = (phases_in_dest >= DestLimit) || (phases_in_dest == DestMissing);
  assign dest_dup     = |(bitmap_q & dest_bit);

  always_comb begin
    recon_raw  = Target - {acc_q[AW-1], acc_q};
    recon_data = recon_raw[W-1:0];
    recon_sat  = 1'b0;
    if (recon_raw < LoBound) begin
      recon_data = LoData;
      recon_sat  = 1'b1;
    end else if (recon_raw > HiBound) begin
      recon_data = HiData;
      recon_sat  = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    bitmap_d      = bitmap_q;
    out_valid_d   = out_valid_q & ~phases_out_ready;
    out_data_d    = out_data_q;
    out_dest_d    = out_dest_q;
    frame_error_d = 1'b0;
    saturated_d   = 1'b0;

    case (state_q)
      StCollect: begin
        // Bypass holds the frame state clear, so re-enabling always starts a fresh frame.
        if (!enable) begin
          acc_d    = '0;
          bitmap_d = '0;
        end
        if (in_fire) begin
          out_valid_d = 1'b1;
          out_data_d  = phases_in_data;
          out_dest_d  = phases_in_dest;
          if (enable) begin
            if (dest_illegal) begin
              frame_error_d = 1'b1;
            end else if (dest_dup) begin
              frame_error_d = 1'b1;
              acc_d         = sample_ext;
              bitmap_d      = dest_bit;
            end else begin
              acc_d    = acc_q + sample_ext;
              bitmap_d = bitmap_q | dest_bit;
            end
            if (bitmap_d == FullMask) begin
              state_d = StEmit;
            end
          end
        end
      end
      StEmit: begin
        // Completes regardless of enable so a frame already collected is never lost.
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = recon_data;
          out_dest_d  = DestMissing;
          saturated_d = recon_sat;
          acc_d       = '0;
          bitmap_d    = '0;
          state_d     = StCollect;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StCollect;
      acc_q         <= '0;
      bitmap_q      <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_dest_q    <= '0;
      frame_error_q <= 1'b0;
      saturated_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      bitmap_q      <= bitmap_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_dest_q    <= out_dest_d;
      frame_error_q <= frame_error_d;
      saturated_q   <= saturated_d;
    end
  end

  assign phases_out_valid = out_valid_q;
  assign phases_out_data  = out_data_q;
  assign phases_out_dest  = out_dest_q;
  assign frame_error      = frame_error_q;
  assign saturated        = saturated_q;

endmodule

// File: tb/tb_phase_reconstructor_ng.sv
// Bench for phase_reconstructor_ng: default unsigned instance against a frame-level model,
// plus a small signed instance with directed frames.
module tb_phase_reconstructor_ng;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable;
  logic [15:0] in_data;
  logic [7:0]  in_dest;
  logic        in_valid, in_ready;
  logic [15:0] out_data;
  logic [7:0]  out_dest;
  logic        out_valid, out_ready;
  logic        frame_error, saturated;

  logic [15:0] s_in_data;
  logic [7:0]  s_in_dest;
  logic        s_in_valid, s_in_ready;
  logic [15:0] s_out_data;
  logic [7:0]  s_out_dest;
  logic        s_out_valid, s_out_ready;
  logic        s_frame_error, s_saturated;

  int checks = 0;
  int errors = 0;
  int exp_data_q[$];
  int exp_dest_q[$];
  bit seen_ph[5];
  int frame_sum;
  int exp_ferr = 0, exp_sat = 0, seen_ferr = 0, seen_sat = 0;
  int beats_exp = 0, beats_seen = 0;
  bit rnd_ready = 1'b0;
  bit stall_pend = 1'b0;
  logic [15:0] stall_data, last_data;
  logic [7:0]  stall_dest, last_dest;
  int ord[5];

  always #5 clock = ~clock;

  phase_reconstructor_ng u_dut (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .phases_in_data   (in_data),
    .phases_in_dest   (in_dest),
    .phases_in_valid  (in_valid),
    .phases_in_ready  (in_ready),
    .phases_out_data  (out_data),
    .phases_out_dest  (out_dest),
    .phases_out_valid (out_valid),
    .phases_out_ready (out_ready),
    .frame_error      (frame_error),
    .saturated        (saturated)
  );

  phase_reconstructor_ng #(
    .N_PHASES      (3),
    .MISSING_PHASE (2),
    .SIGNED_MODE   (1'b1),
    .SUM_TARGET    (0)
  ) u_sgn (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .phases_in_data   (s_in_data),
    .phases_in_dest   (s_in_dest),
    .phases_in_valid  (s_in_valid),
    .phases_in_ready  (s_in_ready),
    .phases_out_data  (s_out_data),
    .phases_out_dest  (s_out_dest),
    .phases_out_valid (s_out_valid),
    .phases_out_ready (s_out_ready),
    .frame_error      (s_frame_error),
    .saturated        (s_saturated)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Frame-level reference: sum the five measured phases, inject clamp(196605 - sum) at dest 5.
  function automatic void model_clear();
    for (int i = 0; i < 5; i++) seen_ph[i] = 1'b0;
    frame_sum = 0;
  endfunction

  function automatic void push_beat(input int d, input int v);
    exp_data_q.push_back(v);
    exp_dest_q.push_back(d);
    beats_exp++;
  endfunction

  function automatic void model_accept(input int d, input int v);
    int r;
    bit done;
    push_beat(d, v);
    if (!enable) begin
      model_clear();
      return;
    end
    if (d >= 6 || d == 5) begin
      exp_ferr++;
      return;
    end
    if (seen_ph[d]) begin
      exp_ferr++;
      model_clear();
    end
    seen_ph[d] = 1'b1;
    frame_sum += v;
    done = 1'b1;
    for (int i = 0; i < 5; i++) done &= seen_ph[i];
    if (done) begin
      r = 196605 - frame_sum;
      if (r < 0) begin
        r = 0;
        exp_sat++;
      end else if (r > 65535) begin
        r = 65535;
        exp_sat++;
      end
      push_beat(5, r);
      model_clear();
    end
  endfunction

  // Output monitor: scoreboard pop per completed beat, stability while stalled, pulse counts.
  always @(negedge clock) begin
    if (reset) begin
      stall_pend = 1'b0;
    end else begin
      if (frame_error === 1'b1) seen_ferr++;
      if (saturated === 1'b1) seen_sat++;
      if (stall_pend) begin
        check("stall_valid", 32'(out_valid), 1);
        check("stall_data", 32'(out_data), 32'(stall_data));
        check("stall_dest", 32'(out_dest), 32'(stall_dest));
      end
      stall_pend = out_valid & ~out_ready;
      stall_data = out_data;
      stall_dest = out_dest;
      if (out_valid && out_ready) begin
        beats_seen++;
        last_data = out_data;
        last_dest = out_dest;
        if (exp_data_q.size() > 0) begin
          check("beat_data", 32'(out_data), exp_data_q.pop_front());
          check("beat_dest", 32'(out_dest), exp_dest_q.pop_front());
        end
      end
    end
  end

  task automatic send(input int d, input int v);
    bit hs;
    hs = 1'b0;
    in_dest  = d[7:0];
    in_data  = v[15:0];
    in_valid = 1'b1;
    for (int i = 0; i < 64 && !hs; i++) begin
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      hs = in_ready;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    check("send_handshake", 32'(hs), 1);
    if (hs) begin
      check("lat_valid", 32'(out_valid), 1);
      check("lat_data", 32'(out_data), 32'(v[15:0]));
      check("lat_dest", 32'(out_dest), 32'(d[7:0]));
      model_accept(d, v);
    end
  endtask

  task automatic send_s(input int d, input int v);
    bit hs;
    hs = 1'b0;
    s_in_dest  = d[7:0];
    s_in_data  = v[15:0];
    s_in_valid = 1'b1;
    for (int i = 0; i < 64 && !hs; i++) begin
      @(negedge clock);
      hs = s_in_ready;
      @(posedge clock);
      #1;
    end
    s_in_valid = 1'b0;
    check("sgn_handshake", 32'(hs), 1);
  endtask

  task automatic idle(input int n);
    out_ready = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic reset_checks();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_dest", 32'(out_dest), 0);
    check("rst_frame_error", 32'(frame_error), 0);
    check("rst_saturated", 32'(saturated), 0);
    check("rst_in_ready", 32'(in_ready), 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset_checks();
    beats_exp -= exp_data_q.size();
    exp_data_q.delete();
    exp_dest_q.delete();
    model_clear();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic set_enable(input bit b);
    out_ready = 1'b1;
    enable = b;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
  endtask

  function automatic int rdata();
    case ($urandom_range(0, 7))
      0:       return 0;
      1:       return 65535;
      default: return int'($urandom_range(0, 65535));
    endcase
  endfunction

  initial begin
    enable = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_dest = '0;
    out_ready = 1'b1;
    s_in_valid = 1'b0;
    s_in_data = '0;
    s_in_dest = '0;
    s_out_ready = 1'b1;
    model_clear();

    repeat (2) @(posedge clock);
    #1;
    reset_checks();
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("ready_after_reset", 32'(in_ready), 1);

    // Signed instance: -1000 + 400 -> 600; 30000 + 30000 clamps to -32768.
    send_s(0, -1000);
    send_s(1, 400);
    @(negedge clock);
    check("sgn_pass_data", 32'($signed(s_out_data)), 400);
    @(negedge clock);
    check("sgn_recon_data", 32'($signed(s_out_data)), 600);
    check("sgn_recon_dest", 32'(s_out_dest), 2);
    check("sgn_recon_sat", 32'(s_saturated), 0);
    send_s(0, 30000);
    send_s(1, 30000);
    @(negedge clock);
    @(negedge clock);
    check("sgn_clamp_data", 32'($signed(s_out_data)), -32768);
    check("sgn_clamp_dest", 32'(s_out_dest), 2);
    check("sgn_clamp_sat", 32'(s_saturated), 1);
    @(posedge clock);
    #1;

    // Nominal frame.
    for (int i = 0; i < 5; i++) send(i, (i + 1) * 10000);
    idle(4);
    check("t1_recon_dest", 32'(last_dest), 5);
    check("t1_recon_data", 32'(last_data), 46605);
    check("t1_sat_count", seen_sat, 0);

    // Full-scale inputs clip to zero.
    for (int i = 0; i < 5; i++) send(i, 65535);
    idle(4);
    check("t2_recon_data", 32'(last_data), 0);
    check("t2_sat_count", seen_sat, 1);

    // Duplicate restarts the frame; completion needs a fresh dest 0.
    send(0, 11111);
    send(1, 22222);
    send(1, 30000);
    send(2, 40000);
    send(3, 50000);
    send(4, 60000);
    idle(4);
    check("t3_no_recon_dest", 32'(last_dest), 4);
    check("t3_ferr_count", seen_ferr, 1);
    send(0, 10000);
    idle(4);
    check("t3_recon_data", 32'(last_data), 6605);
    check("t3_recon_dest", 32'(last_dest), 5);

    // Illegal dests pass through but never accumulate.
    send(2, 30000);
    send(7, 123);
    send(5, 456);
    send(0, 40000);
    send(1, 35000);
    send(3, 25000);
    send(4, 21000);
    idle(4);
    check("t4_recon_data", 32'(last_data), 45605);
    check("t4_ferr_count", seen_ferr, 3);

    // Backpressure during emit.
    for (int i = 0; i < 4; i++) send(i, (i + 1) * 10000);
    send(4, 50000);
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clock);
      check("stall_in_ready", 32'(in_ready), 0);
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    @(negedge clock);
    check("rel_in_ready", 32'(in_ready), 0);
    check("rel_held_dest", 32'(out_dest), 4);
    @(negedge clock);
    check("rel_recon_dest", 32'(out_dest), 5);
    check("rel_recon_data", 32'(out_data), 46605);
    check("rel_in_ready_after", 32'(in_ready), 1);
    @(posedge clock);
    #1;
    send(0, 1234);
    idle(2);

    // Reset mid-frame discards the partial frame.
    pulse_reset();
    for (int i = 0; i < 3; i++) send(i, 1000 * (i + 1));
    pulse_reset();
    for (int i = 0; i < 5; i++) send(i, (i + 1) * 10000);
    idle(4);
    check("t5_recon_data", 32'(last_data), 46605);

    // Partial frame, bypass, then a fresh frame.
    send(0, 5000);
    send(1, 5000);
    set_enable(1'b0);
    for (int i = 0; i < 6; i++) send(i, 1000 * (i + 1));
    idle(4);
    check("byp_last_dest", 32'(last_dest), 5);
    check("byp_last_data", 32'(last_data), 6000);
    check("byp_beats", beats_seen, beats_exp);
    set_enable(1'b1);
    for (int i = 0; i < 5; i++) send(i, (i + 1) * 10000);
    idle(4);
    check("t6_recon_data", 32'(last_data), 46605);
    check("t6_ferr_count", seen_ferr, exp_ferr);

    // Randomized frames with noise, random backpressure and enable toggles.
    rnd_ready = 1'b1;
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 14) == 0) set_enable(~enable);
      for (int i = 0; i < 5; i++) ord[i] = i;
      for (int i = 4; i > 0; i--) begin
        int j, t;
        j = int'($urandom_range(0, i));
        t = ord[i];
        ord[i] = ord[j];
        ord[j] = t;
      end
      for (int k = 0; k < 5; k++) begin
        if ($urandom_range(0, 9) == 0) begin
          if ($urandom_range(0, 1) == 1) send(int'($urandom_range(5, 9)), rdata());
          else send(int'($urandom_range(0, 4)), rdata());
        end
        send(ord[k], rdata());
      end
    end
    rnd_ready = 1'b0;
    idle(8);

    check("end_queue_empty", exp_data_q.size(), 0);
    check("end_beat_total", beats_seen, beats_exp);
    check("end_ferr_count", seen_ferr, exp_ferr);
    check("end_sat_count", seen_sat, exp_sat);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
